// File: rtl/sample_gearbox.sv
// Sample-rate gearbox: IN_N samples per input beat in, OUT_N samples per output beat out,
// through a shift-buffer where entry 0 always holds the oldest buffered sample.
module sample_gearbox #(
    parameter int SAMPLE_W = 14,
    parameter int IN_N     = 5,
    parameter int OUT_N    = 2,
    parameter int BUF_N    = 16
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               flush,
    input  logic [IN_N-1:0][SAMPLE_W-1:0]      in_data,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [OUT_N-1:0][SAMPLE_W-1:0]     out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [$clog2(BUF_N+1)-1:0]         level
);

    localparam int CW = $clog2(BUF_N + 1);
    localparam int NW = $clog2(BUF_N + IN_N + 1);
    localparam int IW = $clog2(BUF_N);

    generate
        if (IN_N < 1 || OUT_N < 1 || BUF_N < IN_N + OUT_N) begin : g_bad_params
            $error("sample_gearbox: need IN_N>=1, OUT_N>=1 and BUF_N >= IN_N+OUT_N");
        end
    endgenerate

    logic [BUF_N-1:0][SAMPLE_W-1:0] data_q;
    logic [BUF_N-1:0][SAMPLE_W-1:0] data_d;
    logic [CW-1:0]                  count_q;
    logic [NW-1:0]                  count_ext;
    logic [NW-1:0]                  base;
    logic [NW-1:0]                  count_d;
    logic [IW-1:0]                  idx;
    logic                           run_q;
    logic                           push;
    logic                           pop;

    // Handshakes: a beat transfers on an edge where valid and ready are both high.
    // Ready/valid come only from registered count, run and flush, never from the peer's signal.
    always_comb begin
        count_ext = NW'(count_q);
        in_ready  = run_q && !flush && (count_ext + NW'(IN_N) <= NW'(BUF_N));
        out_valid = run_q && !flush && (count_ext >= NW'(OUT_N));
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
        base      = pop ? count_ext - NW'(OUT_N) : count_ext;
        count_d   = base + (push ? NW'(IN_N) : '0);
        data_d    = pop ? (data_q >> (OUT_N * SAMPLE_W)) : data_q;
        idx       = '0;
        // New samples land right after whatever survives this cycle's pop.
        if (push) begin
            for (int j = 0; j < IN_N; j++) begin
                idx         = IW'(base + NW'(j));
                data_d[idx] = in_data[j];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_q   <= 1'b0;
            count_q <= '0;
            data_q  <= '0;
        end else begin
            run_q <= 1'b1;
            if (flush) begin
                count_q <= '0;
            end else begin
                count_q <= CW'(count_d);
                data_q  <= data_d;
            end
        end
    end

    assign out_data = data_q[OUT_N-1:0];
    assign level    = count_q;

endmodule

// File: tb/tb_sample_gearbox.sv
// Bench for sample_gearbox: a 5:2/16 instance with directed vectors and a 2:5/8 instance
// with random flow control, both checked against an independent queue model.
module tb_sample_gearbox;

    localparam int SW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic flush;
    logic b_rst_n;
    logic b_flush;

    logic [4:0][SW-1:0] a_in_data;
    logic               a_in_valid;
    logic               a_in_ready;
    logic [1:0][SW-1:0] a_out_data;
    logic               a_out_valid;
    logic               a_out_ready;
    logic [4:0]         a_level;

    logic [1:0][SW-1:0] b_in_data;
    logic               b_in_valid;
    logic               b_in_ready;
    logic [4:0][SW-1:0] b_out_data;
    logic               b_out_valid;
    logic               b_out_ready;
    logic [3:0]         b_level;

    sample_gearbox #(.SAMPLE_W(SW), .IN_N(5), .OUT_N(2), .BUF_N(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .level(a_level)
    );

    sample_gearbox #(.SAMPLE_W(SW), .IN_N(2), .OUT_N(5), .BUF_N(8)) dut_b (
        .clk(clk), .reset_n(b_rst_n), .flush(b_flush),
        .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .level(b_level)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboards: expected samples in arrival order, plus model run flags.
    logic [SW-1:0] exp_q[$];
    logic [SW-1:0] exp_b_q[$];
    bit ma_run;
    bit mb_run;
    int a_push_n;
    int a_pop_n;
    int b_push_n;
    int b_pop_n;

    task automatic set_a(input bit v, input bit r, input int base);
        a_in_valid  = v;
        a_out_ready = r;
        for (int j = 0; j < 5; j++) a_in_data[j] = SW'(base + j);
    endtask

    // Called at a falling edge with inputs set; checks, updates the model, advances one cycle.
    task automatic cycle_a();
        bit er, ev, push, pop;
        #1;
        er = ma_run && !flush && (exp_q.size() + 5 <= 16);
        ev = ma_run && !flush && (exp_q.size() >= 2);
        check_eq("a_in_ready", a_in_ready, er);
        check_eq("a_out_valid", a_out_valid, ev);
        check_eq("a_level", a_level, exp_q.size());
        push = a_in_valid && er;
        pop  = ev && a_out_ready;
        if (pop) begin
            for (int k = 0; k < 2; k++) check_eq("a_out_data", a_out_data[k], exp_q.pop_front());
            a_pop_n++;
        end
        if (push) begin
            for (int j = 0; j < 5; j++) exp_q.push_back(a_in_data[j]);
            a_push_n++;
        end
        if (flush) exp_q.delete();
        @(posedge clk);
        if (reset_n) ma_run = 1'b1;
        @(negedge clk);
    endtask

    task automatic cycle_b();
        bit er, ev, push, pop;
        #1;
        er = mb_run && (exp_b_q.size() + 2 <= 8);
        ev = mb_run && (exp_b_q.size() >= 5);
        check_eq("b_in_ready", b_in_ready, er);
        check_eq("b_out_valid", b_out_valid, ev);
        check_eq("b_level", b_level, exp_b_q.size());
        check_eq("b_level_max", b_level <= 4'd8, 1);
        push = b_in_valid && er;
        pop  = ev && b_out_ready;
        if (pop) begin
            for (int k = 0; k < 5; k++) check_eq("b_out_data", b_out_data[k], exp_b_q.pop_front());
            b_pop_n++;
        end
        if (push) begin
            for (int j = 0; j < 2; j++) exp_b_q.push_back(b_in_data[j]);
            b_push_n++;
        end
        @(posedge clk);
        if (b_rst_n) mb_run = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        b_rst_n = 1'b0;
        flush   = 1'b0;
        b_flush = 1'b0;
        ma_run  = 1'b0;
        mb_run  = 1'b0;
        a_push_n = 0; a_pop_n = 0; b_push_n = 0; b_pop_n = 0;
        set_a(0, 0, 0);
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_level", a_level, 0);
        check_eq("rst_in_ready", a_in_ready, 0);
        check_eq("rst_out_valid", a_out_valid, 0);
        check_eq("rst_out_data", a_out_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        cycle_a();
        check_eq("rst_ready_2nd", a_in_ready, 1);

        // Basic 5:2
        set_a(1, 1, 1);
        cycle_a();
        check_eq("basic_lane0", a_out_data[0], 1);
        check_eq("basic_lane1", a_out_data[1], 2);
        set_a(0, 1, 0);
        cycle_a();
        check_eq("basic_l0_34", a_out_data[0], 3);
        cycle_a();
        check_eq("basic_level1", a_level, 1);
        check_eq("basic_nvalid", a_out_valid, 0);
        check_eq("basic_resid", a_out_data[0], 5);
        set_a(1, 1, 6);
        cycle_a();
        check_eq("basic2_lane0", a_out_data[0], 5);
        check_eq("basic2_lane1", a_out_data[1], 6);
        set_a(0, 1, 0);
        repeat (3) cycle_a();
        check_eq("basic_empty", a_level, 0);

        // Full
        a_push_n = 0;
        for (int i = 0; i < 5; i++) begin
            set_a(1, 0, 20 + 5 * a_push_n);
            cycle_a();
        end
        check_eq("full_beats", a_push_n, 3);
        check_eq("full_level", a_level, 15);
        check_eq("full_nready", a_in_ready, 0);
        set_a(1, 1, 20 + 5 * a_push_n);
        cycle_a();
        check_eq("full_pop1_level", a_level, 13);
        check_eq("full_pop1_nready", a_in_ready, 0);
        cycle_a();
        check_eq("full_pop2_level", a_level, 11);
        check_eq("full_pop2_ready", a_in_ready, 1);
        check_eq("full_beats2", a_push_n, 3);
        set_a(1, 0, 20 + 5 * a_push_n);
        cycle_a();
        check_eq("full_beats3", a_push_n, 4);
        check_eq("full_level16", a_level, 16);
        set_a(0, 1, 0);
        repeat (8) cycle_a();
        check_eq("full_drained", a_level, 0);

        // Streaming
        a_push_n = 0;
        a_pop_n  = 0;
        for (int i = 0; i < 1000; i++) begin
            set_a(1, 1, 100 + 5 * a_push_n);
            cycle_a();
        end
        check_eq("stream_pops", a_pop_n, 999);
        set_a(0, 1, 0);
        repeat (10) cycle_a();
        flush = 1'b1;
        cycle_a();
        flush = 1'b0;

        // Flush with handshakes offered
        set_a(1, 0, 200); cycle_a();
        set_a(1, 1, 205); cycle_a();
        set_a(1, 1, 210); cycle_a();
        set_a(0, 1, 0);   cycle_a();
        cycle_a();
        check_eq("flush_pre_level", a_level, 7);
        a_push_n = 0;
        a_pop_n  = 0;
        flush = 1'b1;
        set_a(1, 1, 300);
        cycle_a();
        flush = 1'b0;
        check_eq("flush_no_push", a_push_n, 0);
        check_eq("flush_no_pop", a_pop_n, 0);
        check_eq("flush_level0", a_level, 0);
        set_a(1, 0, 300);
        cycle_a();
        check_eq("flush_lane0", a_out_data[0], 300);
        check_eq("flush_lane1", a_out_data[1], 301);
        check_eq("flush_level5", a_level, 5);

        // Reset mid-stream
        flush = 1'b1;
        cycle_a();
        flush = 1'b0;
        set_a(1, 0, 400); cycle_a();
        set_a(1, 1, 405); cycle_a();
        set_a(1, 1, 410); cycle_a();
        set_a(0, 1, 0);   cycle_a();
        check_eq("mid_pre_level", a_level, 9);
        #3;
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_level", a_level, 0);
        check_eq("mid_rst_valid", a_out_valid, 0);
        check_eq("mid_rst_ready", a_in_ready, 0);
        check_eq("mid_rst_data", a_out_data, 0);
        exp_q.delete();
        ma_run = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        set_a(1, 1, 500);
        cycle_a();
        check_eq("mid_ready_after", a_in_ready, 1);
        cycle_a();
        set_a(0, 1, 0);
        repeat (4) cycle_a();
        check_eq("mid_resid", a_level, 1);

        // Expansion 2:5 with random flow control
        @(negedge clk);
        b_rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_data[0] = SW'(1000 + 2 * b_push_n);
            b_in_data[1] = SW'(1001 + 2 * b_push_n);
            cycle_b();
        end
        check_eq("b_some_pops", b_pop_n > 10, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_gearbox.md
# sample_gearbox

Parametrised single-clock sample-rate gearbox for the DAC data path. Accepts IN_N samples per input beat and emits OUT_N samples per output beat through a shift-buffer, with valid/ready flow control on both sides. It is the general successor to the fixed 5-to-2 data multiplexing stage. It sits between the sample generator and the OSERDES feed, and supports any IN_N:OUT_N ratio, including expansion (OUT_N > IN_N).

## Interface
Parameters:
- SAMPLE_W, 14, bits per sample
- IN_N, 5, samples per input beat (>=1)
- OUT_N, 2, samples per output beat (>=1)
- BUF_N, 16, buffer capacity in samples; must be >= IN_N+OUT_N (elaboration error otherwise)

Ports:
- clk  in  1  sole clock; all state on rising edge
- reset_n  in  1  asynchronous assert, active-low
- flush  in  1  synchronous discard of buffer contents
- in_data  in  IN_N x SAMPLE_W  lane 0 = oldest sample
- in_valid  in  1  input beat offered
- in_ready  out  1  gearbox accepts a beat this cycle
- out_data  out  OUT_N x SAMPLE_W  lane 0 = oldest sample
- out_valid  out  1  out_data holds OUT_N valid samples
- out_ready  in  1  consumer takes out_data this cycle
- level  out  $clog2(BUF_N+1)  samples currently buffered

## Operation
- State: buf[0..BUF_N-1] (SAMPLE_W each, buf[0] oldest), count (0..BUF_N), run flag.
- run: cleared by reset; set on the first clk edge with reset_n high. Gates both handshakes.
- in_ready = run & !flush & (count + IN_N <= BUF_N). It is derived from the registered count only. There is no combinational path from out_ready.
- out_valid = run & !flush & (count >= OUT_N).
- out_data lane k = buf[k], driven directly from registers.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Per edge, no flush:
  - buffer shifts down by OUT_N if pop.
  - If push, in_data lane j is written to buf[count - (pop ? OUT_N : 0) + j].
  - count_next = count + (push ? IN_N : 0) - (pop ? OUT_N : 0).
- Simultaneous push and pop are always legal. Sample order is preserved exactly; no sample is duplicated or dropped.
- flush=1: count <- 0 and handshakes are suppressed. Buffer data need not be cleared.
- level = count, registered.
- Widths: count_next arithmetic is at least $clog2(BUF_N+IN_N+1) bits. No wrap is possible because in_ready guarantees count_next <= BUF_N.

## Timing
- Reset values (reset_n low): count=0, level=0, run=0, in_ready=0, out_valid=0, out_data=0.
- In the first cycle after reset_n rises, in_ready=0. In the second cycle, in_ready=1.
- Latency: a beat pushed at edge k is visible on out_data after edge k, provided count then reaches OUT_N.
- Full: count+IN_N > BUF_N forces in_ready=0 even if a pop occurs in the same cycle. A pop frees space from the next cycle on.
- Empty/short: count < OUT_N gives out_valid=0. Residual samples (count mod OUT_N) stay until more input arrives or a flush occurs.
- Sustained throughput with in_valid=out_ready=1 is min(IN_N, OUT_N) samples per cycle on average.
- reset_n asserted mid-operation: all state clears immediately (asynchronous). Buffered samples are lost.
- flush together with in_valid/out_ready: no handshake completes, and count=0 next cycle.
- in_data is sampled only on push, so it may change freely while in_ready=0.

## Test plan
- Basic 5:2: reset, then push one beat (1,2,3,4,5) with out_ready=1. Output beats are (1,2) then (3,4), out_valid drops, level=1. A second beat (6..10) yields (5,6),(7,8),(9,10).
- Full: out_ready=0, in_valid=1 continuously, BUF_N=16. Exactly 3 beats are accepted, level=15, in_ready=0. The next push is accepted only after two pops (level 11).
- Streaming: in_valid=out_ready=1 for 1000 cycles with an incrementing sample pattern. The output is a gap-free incrementing sequence at 2 samples/cycle, and the scoreboard shows zero loss.
- Expansion 2:5 (IN_N=2, OUT_N=5, BUF_N=8): random in_valid/out_ready. In-order output, out_valid only when level >= 5, level never exceeds 8.
- Flush: level=7, then assert flush with in_valid=out_ready=1. No handshakes in that cycle, level=0 after, and the next pushed beat appears at lane 0.
- Reset mid-stream: drop reset_n with level=9. All outputs go to 0 asynchronously. After release, in_ready=0 for one cycle, then 1.
